// File: rtl/apu_wavegen_tri.sv
// Triangle/sawtooth wave channel (linear counter, length counter, period timer, sequencer).
// Optional macro APU_TRI_ULTRASONIC_MUTE_EN freezes the channel while period < 2.

module apu_length (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       halt,
    input  logic       halfframe,
    input  logic       load,
    input  logic [4:0] idx,
    output logic       active
);

    logic [7:0] count;
    logic [7:0] load_val;

    always_comb begin
        load_val = 8'd0;
        case (idx)
            5'd0:  load_val = 8'd10;   5'd1:  load_val = 8'd254;
            5'd2:  load_val = 8'd20;   5'd3:  load_val = 8'd2;
            5'd4:  load_val = 8'd40;   5'd5:  load_val = 8'd4;
            5'd6:  load_val = 8'd80;   5'd7:  load_val = 8'd6;
            5'd8:  load_val = 8'd160;  5'd9:  load_val = 8'd8;
            5'd10: load_val = 8'd60;   5'd11: load_val = 8'd10;
            5'd12: load_val = 8'd14;   5'd13: load_val = 8'd12;
            5'd14: load_val = 8'd26;   5'd15: load_val = 8'd14;
            5'd16: load_val = 8'd12;   5'd17: load_val = 8'd16;
            5'd18: load_val = 8'd24;   5'd19: load_val = 8'd18;
            5'd20: load_val = 8'd48;   5'd21: load_val = 8'd20;
            5'd22: load_val = 8'd96;   5'd23: load_val = 8'd22;
            5'd24: load_val = 8'd192;  5'd25: load_val = 8'd24;
            5'd26: load_val = 8'd72;   5'd27: load_val = 8'd26;
            5'd28: load_val = 8'd16;   5'd29: load_val = 8'd28;
            5'd30: load_val = 8'd32;   5'd31: load_val = 8'd30;
            default: load_val = 8'd0;
        endcase
    end

    // Disable beats a pending load so a write to a muted channel stays silent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= 8'd0;
        else if (!en)
            count <= 8'd0;
        else if (load)
            count <= load_val;
        else if (halfframe && !halt && count != 8'd0)
            count <= count - 8'd1;
    end

    assign active = (count != 8'd0);

endmodule

module apu_wavegen_tri #(
    parameter int TIMER_W = 11,
    parameter int LIN_W   = 7,
    parameter int SEQ_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               qtrframe,
    input  logic               halfframe,
    input  logic               en,
    input  logic               ctrl_flag,
    input  logic [LIN_W-1:0]   linear_reload,
    input  logic [TIMER_W-1:0] period,
    input  logic [4:0]         len_idx,
    input  logic               mode,
    input  logic               update,
    output logic               active,
    output logic               step,
    output logic [SEQ_W-1:0]   sample
);

    typedef enum logic {DIR_DOWN, DIR_UP} dir_t;

    localparam logic [SEQ_W-1:0] SAMPLE_MAX = '1;

    dir_t               dir;
    logic [LIN_W-1:0]   linear;
    logic               reload_flag;
    logic [TIMER_W-1:0] timer;
    logic               ultra;
    logic               run;
    logic               tick;

    apu_length u_length (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .halt      (ctrl_flag),
        .halfframe (halfframe),
        .load      (update),
        .idx       (len_idx),
        .active    (active)
    );

`ifdef APU_TRI_ULTRASONIC_MUTE_EN
    assign ultra = (period < TIMER_W'(2));
`else
    assign ultra = 1'b0;
`endif

    assign run = active && (linear != '0) && !ultra;

    always_comb begin
        tick = 1'b0;
        if (!update && run && timer == '0)
            tick = 1'b1;
    end

    // A write arriving with a quarter-frame both reloads and keeps the flag armed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            linear      <= '0;
            reload_flag <= 1'b0;
        end else begin
            if (qtrframe) begin
                if (reload_flag || update)
                    linear <= linear_reload;
                else if (linear != '0)
                    linear <= linear - LIN_W'(1);
            end
            if (update)
                reload_flag <= 1'b1;
            else if (qtrframe && !ctrl_flag)
                reload_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timer <= '0;
        else if (update)
            timer <= period;
        else if (run) begin
            if (timer == '0)
                timer <= period;
            else
                timer <= timer - TIMER_W'(1);
        end
    end

    // Triangle endpoints repeat once on direction change; saw simply wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample <= SAMPLE_MAX;
            dir    <= DIR_DOWN;
            step   <= 1'b0;
        end else begin
            step <= tick;
            if (tick) begin
                if (mode)
                    sample <= sample + SEQ_W'(1);
                else if (dir == DIR_DOWN) begin
                    if (sample != '0)
                        sample <= sample - SEQ_W'(1);
                    else
                        dir <= DIR_UP;
                end else begin
                    if (sample != SAMPLE_MAX)
                        sample <= sample + SEQ_W'(1);
                    else
                        dir <= DIR_DOWN;
                end
            end
        end
    end

endmodule

// File: tb/tb_apu_wavegen_tri.sv
// Directed self-checking bench for apu_wavegen_tri (default parameters).
// Honours APU_TRI_ULTRASONIC_MUTE_EN for the P=0/P=1 expectations.

module tb_apu_wavegen_tri;

    logic        clk = 1'b0;
    logic        rst;
    logic        qtrframe;
    logic        halfframe;
    logic        en;
    logic        ctrl_flag;
    logic [6:0]  linear_reload;
    logic [10:0] period;
    logic [4:0]  len_idx;
    logic        mode;
    logic        update;
    logic        active;
    logic        step;
    logic [3:0]  sample;

    int checks = 0;
    int errors = 0;

`ifdef APU_TRI_ULTRASONIC_MUTE_EN
    localparam bit ULTRA_MUTE = 1'b1;
`else
    localparam bit ULTRA_MUTE = 1'b0;
`endif

    apu_wavegen_tri dut (
        .clk           (clk),
        .rst           (rst),
        .qtrframe      (qtrframe),
        .halfframe     (halfframe),
        .en            (en),
        .ctrl_flag     (ctrl_flag),
        .linear_reload (linear_reload),
        .period        (period),
        .len_idx       (len_idx),
        .mode          (mode),
        .update        (update),
        .active        (active),
        .step          (step),
        .sample        (sample)
    );

    always #5 clk = ~clk;

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulses the update/quarter-frame strobes across exactly one rising edge.
    task automatic applyStimulus(input logic upd, input logic qf);
        update   = upd;
        qtrframe = qf;
        waitCycles(1);
        update   = 1'b0;
        qtrframe = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Value after the k-th step of a triangle cycle starting at 15, going down.
    function automatic int triExpected(input int k);
        int m;
        m = ((k - 1) % 32) + 1;
        if (m <= 15)      return 15 - m;
        else if (m == 16) return 0;
        else if (m <= 31) return m - 16;
        else              return 15;
    endfunction

    initial begin
        rst = 1'b1; qtrframe = 1'b0; halfframe = 1'b0; en = 1'b0; ctrl_flag = 1'b0;
        linear_reload = 7'd0; period = 11'd0; len_idx = 5'd0; mode = 1'b0; update = 1'b0;
        waitCycles(2);
        checkOutput("reset_sample", 32'(sample), 32'd15);
        checkOutput("reset_active", 32'(active), 32'd0);
        checkOutput("reset_step", 32'(step), 32'd0);
        rst = 1'b0;
        waitCycles(1);

        $display("[TB] triangle, P=3");
        en = 1'b1; period = 11'd3; linear_reload = 7'd10; len_idx = 5'd1;
        applyStimulus(1'b1, 1'b0);
        checkOutput("tri_active", 32'(active), 32'd1);
        applyStimulus(1'b0, 1'b1);
        for (int k = 1; k <= 33; k++) begin
            for (int j = 0; j < 3; j++) begin
                waitCycles(1);
                checkOutput("tri_no_step", 32'(step), 32'd0);
            end
            waitCycles(1);
            checkOutput("tri_step", 32'(step), 32'd1);
            checkOutput("tri_sample", 32'(sample), 32'(triExpected(k)));
        end

        $display("[TB] mid-run reset");
        rst = 1'b1;
        #1;
        checkOutput("midrst_sample", 32'(sample), 32'd15);
        checkOutput("midrst_active", 32'(active), 32'd0);
        checkOutput("midrst_step", 32'(step), 32'd0);
        waitCycles(1);
        rst = 1'b0;
        waitCycles(1);

        $display("[TB] linear counter expiry");
        period = 11'd3; linear_reload = 7'd2; len_idx = 5'd1; ctrl_flag = 1'b0; mode = 1'b0;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("lin_loaded", 32'(dut.linear), 32'd2);
        waitCycles(3);
        checkOutput("lin_pre_step", 32'(step), 32'd0);
        waitCycles(1);
        checkOutput("lin_step", 32'(step), 32'd1);
        checkOutput("lin_sample", 32'(sample), 32'd14);
        applyStimulus(1'b0, 1'b1);
        checkOutput("lin_dec1", 32'(dut.linear), 32'd1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("lin_zero", 32'(dut.linear), 32'd0);
        for (int i = 0; i < 10; i++) begin
            waitCycles(1);
            checkOutput("lin_frozen_step", 32'(step), 32'd0);
            checkOutput("lin_frozen_sample", 32'(sample), 32'd14);
        end
        applyStimulus(1'b1, 1'b1);
        checkOutput("lin_upd_qf_linear", 32'(dut.linear), 32'd2);
        checkOutput("lin_upd_qf_flag", 32'(dut.reload_flag), 32'd1);

        $display("[TB] disable while running");
        waitCycles(3);
        checkOutput("dis_pre_step", 32'(step), 32'd0);
        waitCycles(1);
        checkOutput("dis_step", 32'(step), 32'd1);
        checkOutput("dis_sample", 32'(sample), 32'd13);
        en = 1'b0;
        waitCycles(1);
        checkOutput("dis_active", 32'(active), 32'd0);
        for (int i = 0; i < 12; i++) begin
            waitCycles(1);
            checkOutput("dis_step_off", 32'(step), 32'd0);
            checkOutput("dis_sample_held", 32'(sample), 32'd13);
        end

        $display("[TB] sawtooth, P=0");
        rst = 1'b1;
        waitCycles(1);
        rst = 1'b0;
        checkOutput("saw_start", 32'(sample), 32'd15);
        en = 1'b1; mode = 1'b1; period = 11'd0; linear_reload = 7'd10; len_idx = 5'd1;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("saw_no_step_yet", 32'(step), 32'd0);
        for (int k = 0; k <= 16; k++) begin
            waitCycles(1);
            checkOutput("saw_step", 32'(step), ULTRA_MUTE ? 32'd0 : 32'd1);
            checkOutput("saw_sample", 32'(sample), ULTRA_MUTE ? 32'd15 : 32'(k % 16));
        end

        $display("[TB] P=1 step rate");
        mode = 1'b0; period = 11'd1;
        applyStimulus(1'b1, 1'b0);
        checkOutput("p1_update_step", 32'(step), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            waitCycles(1);
            checkOutput("p1_step", 32'(step), (ULTRA_MUTE || (i % 2 == 1)) ? 32'd0 : 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
